// File: rtl/latent_decoder_neuron_pkg.sv
// rtl/latent_decoder_neuron_pkg.sv - shared types, constants and saturation helper for the decoder neuron
//
// Purpose: state encoding, default word format and a generic signed saturate
// function shared by the neuron top level and its MAC sub-module.
package latent_decoder_neuron_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_FINISH = 2'd2,
        ST_HOLD   = 2'd3
    } neuron_state_t;

    localparam int BITSIZE_DEF = 24;
    localparam int FRAC_DEF    = 16;

    // Output clamp limits for the default word width.
    localparam logic signed [BITSIZE_DEF-1:0] SAT_MAX = 24'sh7FFFFF;
    localparam logic signed [BITSIZE_DEF-1:0] SAT_MIN = 24'sh800000;

    // Clamp a signed value to the range of a two's complement word of 'bits' bits.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                      input int bits);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/latent_decoder_neuron_mac.sv
// rtl/latent_decoder_neuron_mac.sv - signed fixed-point multiply, shift and accumulate
//
// Ports:
//   clk, reset  : clock, synchronous active-low reset
//   clear       : zero the accumulator (frame handed off)
//   en          : accumulate one product this edge
//   start       : first sample of a frame, accumulate onto zero
//   sample      : latent sample z[i]
//   weight      : weight w[i]
//   acc         : running accumulator
module latent_mac_unit
    import latent_decoder_neuron_pkg::*;
#(
    parameter int BITSIZE = BITSIZE_DEF,
    parameter int FRAC    = FRAC_DEF,
    parameter int ACC_W   = 40
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      en,
    input  logic                      start,
    input  logic signed [BITSIZE-1:0] sample,
    input  logic signed [BITSIZE-1:0] weight,
    output logic signed [ACC_W-1:0]   acc
);

    // Wide enough for both the full product and the accumulator, so the
    // shifted product is sign-extended (or safely narrowed) into ACC_W.
    localparam int WIDE = (ACC_W > 2 * BITSIZE) ? ACC_W : 2 * BITSIZE;

    logic signed [2*BITSIZE-1:0] product;
    logic signed [WIDE-1:0]      term;
    logic signed [ACC_W-1:0]     base;

    always_comb begin
        product = sample * weight;
        // Arithmetic shift floors toward -inf, matching Q-format truncation.
        term    = WIDE'(product >>> FRAC);
        base    = start ? '0 : acc;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            acc <= '0;
        else if (clear)
            acc <= '0;
        else if (en)
            acc <= base + term[ACC_W-1:0];
    end

endmodule

// File: rtl/latent_decoder_neuron.sv
// rtl/latent_decoder_neuron.sv - one decoder neuron: act(bias + sum w[i]*z[i]) over a latent frame
//
// Ports:
//   clk, reset           : clock, synchronous active-low reset
//   in_valid/in_ready    : latent sample handshake, in_data = z[i]
//   out_valid/out_ready  : result handshake, out_data = neuron output
//   w_we/w_addr/w_data   : weight register write
//   b_we/b_data          : bias register write
//   busy                 : frame in progress or result pending
module latent_decoder_neuron
    import latent_decoder_neuron_pkg::*;
#(
    parameter int BITSIZE  = BITSIZE_DEF,
    parameter int FRAC     = FRAC_DEF,
    parameter int N_LATENT = 8,
    parameter int ACC_W    = 40,
    parameter int RELU_EN  = 1,
    localparam int AW      = (N_LATENT > 1) ? $clog2(N_LATENT) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BITSIZE-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BITSIZE-1:0] out_data,
    input  logic               w_we,
    input  logic [AW-1:0]      w_addr,
    input  logic [BITSIZE-1:0] w_data,
    input  logic               b_we,
    input  logic [BITSIZE-1:0] b_data,
    output logic               busy
);

    neuron_state_t             state;
    logic [AW-1:0]             count;
    logic signed [BITSIZE-1:0] weights [N_LATENT];
    logic signed [BITSIZE-1:0] bias;
    logic signed [ACC_W-1:0]   acc;

    logic                      accept;
    logic                      last;
    logic signed [ACC_W-1:0]   sum;
    logic signed [63:0]        act;
    logic signed [63:0]        clamped;

    assign in_ready = (state == ST_IDLE) || (state == ST_ACCUM);
    assign busy     = (state != ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign last     = (int'(count) == N_LATENT - 1);

    // Weight is read from the register array before any same-edge write lands.
    latent_mac_unit #(
        .BITSIZE (BITSIZE),
        .FRAC    (FRAC),
        .ACC_W   (ACC_W)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clear  ((state == ST_HOLD) && out_ready),
        .en     (accept),
        .start  (state == ST_IDLE),
        .sample (in_data),
        .weight (weights[count]),
        .acc    (acc)
    );

    // Output stage: add bias (already in Q format), optional ReLU, clamp to word.
    always_comb begin
        sum = acc + ACC_W'(bias);
        act = 64'(sum);
        if (RELU_EN != 0 && sum < 0)
            act = '0;
        clamped = sat_signed(act, BITSIZE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            bias      <= '0;
            for (int i = 0; i < N_LATENT; i++)
                weights[i] <= '0;
        end else begin
            if (w_we && int'(w_addr) < N_LATENT)
                weights[w_addr] <= w_data;
            if (b_we)
                bias <= b_data;

            case (state)
                ST_IDLE, ST_ACCUM: begin
                    if (accept) begin
                        count <= last ? '0 : count + 1'b1;
                        state <= last ? ST_FINISH : ST_ACCUM;
                    end
                end
                ST_FINISH: begin
                    out_data  <= clamped[BITSIZE-1:0];
                    out_valid <= 1'b1;
                    state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_latent_decoder_neuron.sv
// tb/tb_latent_decoder_neuron.sv - self-checking bench for latent_decoder_neuron (ReLU and linear instances)
module tb_latent_decoder_neuron;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        w_we = 1'b0;
    logic [2:0]  w_addr = '0;
    logic [23:0] w_data = '0;
    logic        b_we = 1'b0;
    logic [23:0] b_data = '0;

    logic        in_ready_r, out_valid_r, busy_r;
    logic [23:0] out_data_r;
    logic        in_ready_l, out_valid_l, busy_l;
    logic [23:0] out_data_l;

    int total = 0;
    int bad = 0;

    logic signed [23:0] z_m [8];
    logic signed [23:0] w_m [8];
    logic signed [23:0] b_m;
    longint             acc_m;

    always #5 clk = ~clk;

    latent_decoder_neuron #(.RELU_EN(1)) dut_r (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_r),
        .in_data(in_data), .out_valid(out_valid_r), .out_ready(out_ready),
        .out_data(out_data_r), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .b_we(b_we), .b_data(b_data), .busy(busy_r)
    );

    latent_decoder_neuron #(.RELU_EN(0)) dut_l (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_l),
        .in_data(in_data), .out_valid(out_valid_l), .out_ready(out_ready),
        .out_data(out_data_l), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .b_we(b_we), .b_data(b_data), .busy(busy_l)
    );

    // Reference: real-valued neuron in integer Q units.
    function automatic longint prod_q(input logic signed [23:0] z, input logic signed [23:0] w);
        longint p;
        p = longint'(z) * longint'(w);
        return p >>> 16;
    endfunction

    function automatic logic [23:0] finish_model(input bit relu);
        longint s;
        logic [63:0] r;
        s = acc_m + longint'(b_m);
        if (relu && s < 0) s = 0;
        if (s > 8388607) s = 8388607;
        if (s < -8388608) s = -8388608;
        r = 64'(s);
        return r[23:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input int a, input logic [23:0] v);
        w_we = 1'b1; w_addr = 3'(a); w_data = v;
        tick();
        w_we = 1'b0;
        w_m[a] = v;
    endtask

    task automatic write_b(input logic [23:0] v);
        b_we = 1'b1; b_data = v;
        tick();
        b_we = 1'b0;
        b_m = v;
    endtask

    // Present sample i; optionally write w[i] on the same edge the MAC reads it.
    task automatic sample_step(input int i, input int wr_idx, input logic [23:0] wr_val);
        in_valid = 1'b1;
        in_data  = z_m[i];
        total++;
        if (in_ready_r !== 1'b1 || in_ready_l !== 1'b1) begin
            bad++;
            $display("FAIL in_ready_sample%0d got=%b/%b exp=1", i, in_ready_r, in_ready_l);
        end
        acc_m += prod_q(z_m[i], w_m[i]);
        if (i == wr_idx) begin
            w_we = 1'b1; w_addr = 3'(i); w_data = wr_val;
        end
        tick();
        in_valid = 1'b0;
        w_we = 1'b0;
        if (i == wr_idx) w_m[i] = wr_val;
    endtask

    // Feed samples first..7 with random gaps, check latency and result, optionally release.
    task automatic run_frame(input string name, input int first, input int gap_max,
                             input int wr_idx, input logic [23:0] wr_val, input bit release_out);
        logic [23:0] exp_r, exp_l;
        for (int i = first; i < 8; i++) begin
            repeat ($urandom_range(0, gap_max)) tick();
            sample_step(i, wr_idx, wr_val);
        end
        total++;
        if (out_valid_r !== 1'b0 || out_valid_l !== 1'b0) begin
            bad++;
            $display("FAIL %s_early_valid got=%b/%b exp=0", name, out_valid_r, out_valid_l);
        end
        tick();
        exp_r = finish_model(1'b1);
        exp_l = finish_model(1'b0);
        total++;
        if (out_valid_r !== 1'b1 || out_valid_l !== 1'b1) begin
            bad++;
            $display("FAIL %s_valid got=%b/%b exp=1", name, out_valid_r, out_valid_l);
        end
        total++;
        if (out_data_r !== exp_r) begin
            bad++;
            $display("FAIL %s_relu_data got=%h exp=%h", name, out_data_r, exp_r);
        end
        total++;
        if (out_data_l !== exp_l) begin
            bad++;
            $display("FAIL %s_lin_data got=%h exp=%h", name, out_data_l, exp_l);
        end
        total++;
        if (busy_r !== 1'b1) begin
            bad++;
            $display("FAIL %s_busy_hold got=%b exp=1", name, busy_r);
        end
        if (release_out) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            total++;
            if (out_valid_r !== 1'b0 || busy_r !== 1'b0 || in_ready_r !== 1'b1) begin
                bad++;
                $display("FAIL %s_release got valid=%b busy=%b ready=%b exp=0/0/1",
                         name, out_valid_r, busy_r, in_ready_r);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) w_m[i] = '0;
        b_m = '0;
        total++;
        if (out_valid_r !== 1'b0 || out_data_r !== 24'h0 || busy_r !== 1'b0 || in_ready_r !== 1'b1) begin
            bad++;
            $display("FAIL reset_state got valid=%b data=%h busy=%b ready=%b exp=0/000000/0/1",
                     out_valid_r, out_data_r, busy_r, in_ready_r);
        end
        // Cleared weights/bias must give a zero result.
        for (int i = 0; i < 8; i++) z_m[i] = 24'h123456;
        acc_m = 0;
        run_frame("reset_zero_weights", 0, 0, -1, '0, 1'b1);
    endtask

    task automatic test_unity;
        for (int i = 0; i < 8; i++) write_w(i, 24'h010000);
        write_b(24'h0);
        for (int i = 0; i < 8; i++) z_m[i] = 24'h008000;
        acc_m = 0;
        run_frame("unity", 0, 0, -1, '0, 1'b1);
        total++;
        if (finish_model(1'b0) !== 24'h040000) begin
            bad++;
            $display("FAIL unity_model got=%h exp=040000", finish_model(1'b0));
        end
    endtask

    task automatic test_negative;
        for (int i = 0; i < 8; i++) write_w(i, 24'hFF0000);
        for (int i = 0; i < 8; i++) z_m[i] = 24'h010000;
        acc_m = 0;
        run_frame("negative", 0, 0, -1, '0, 1'b1);
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 8; i++) write_w(i, 24'h7F0000);
        for (int i = 0; i < 8; i++) z_m[i] = 24'h7F0000;
        acc_m = 0;
        run_frame("sat_pos", 0, 0, -1, '0, 1'b1);
        for (int i = 0; i < 8; i++) write_w(i, 24'h810000);
        acc_m = 0;
        run_frame("sat_neg", 0, 0, -1, '0, 1'b1);
    endtask

    task automatic test_backpressure;
        logic [23:0] held_r, held_l;
        for (int i = 0; i < 8; i++) write_w(i, 24'($urandom));
        write_b(24'($urandom));
        for (int i = 0; i < 8; i++) z_m[i] = 24'($urandom);
        acc_m = 0;
        run_frame("bp_frame", 0, 0, -1, '0, 1'b0);
        held_r = finish_model(1'b1);
        held_l = finish_model(1'b0);
        for (int i = 0; i < 8; i++) z_m[i] = 24'($urandom);
        in_valid = 1'b1;
        in_data  = z_m[0];
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if (out_valid_r !== 1'b1 || out_data_r !== held_r || out_data_l !== held_l || in_ready_r !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold_cycle%0d got valid=%b data=%h/%h ready=%b exp=1/%h/%h/0",
                         c, out_valid_r, out_data_r, out_data_l, in_ready_r, held_r, held_l);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid_r !== 1'b0 || in_ready_r !== 1'b1 || busy_r !== 1'b0) begin
            bad++;
            $display("FAIL bp_release got valid=%b ready=%b busy=%b exp=0/1/0", out_valid_r, in_ready_r, busy_r);
        end
        acc_m = prod_q(z_m[0], w_m[0]);
        tick();
        in_valid = 1'b0;
        total++;
        if (busy_r !== 1'b1) begin
            bad++;
            $display("FAIL bp_first_accept got busy=%b exp=1", busy_r);
        end
        run_frame("bp_next_frame", 1, 0, -1, '0, 1'b1);
    endtask

    task automatic test_gapped;
        for (int i = 0; i < 8; i++) write_w(i, 24'h010000);
        write_b(24'h0);
        for (int i = 0; i < 8; i++) z_m[i] = 24'h008000;
        acc_m = 0;
        // Same-edge write to w[4]: this frame must still see 1.0 there.
        run_frame("gapped", 0, 3, 4, 24'h020000, 1'b1);
        acc_m = 0;
        run_frame("after_write", 0, 0, -1, '0, 1'b1);
    endtask

    task automatic test_random;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) write_w(i, 24'($urandom));
            write_b(24'($urandom));
            for (int i = 0; i < 8; i++) z_m[i] = 24'($urandom);
            acc_m = 0;
            run_frame($sformatf("random%0d", f), 0, 2, -1, '0, 1'b1);
        end
    endtask

    task automatic test_reset_midframe;
        for (int i = 0; i < 8; i++) z_m[i] = 24'h7A5A5A;
        acc_m = 0;
        for (int i = 0; i < 3; i++) sample_step(i, -1, '0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) w_m[i] = '0;
        b_m = '0;
        total++;
        if (busy_r !== 1'b0 || out_valid_r !== 1'b0 || in_ready_r !== 1'b1) begin
            bad++;
            $display("FAIL midreset_state got busy=%b valid=%b ready=%b exp=0/0/1", busy_r, out_valid_r, in_ready_r);
        end
        for (int i = 0; i < 8; i++) write_w(i, 24'h010000);
        write_b(24'h018000);
        for (int i = 0; i < 8; i++) z_m[i] = 24'h010000;
        acc_m = 0;
        run_frame("midreset_frame", 0, 0, -1, '0, 1'b1);
        total++;
        if (out_data_l !== 24'h098000) begin
            bad++;
            $display("FAIL midreset_const got=%h exp=098000", out_data_l);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_unity();
        test_negative();
        test_saturate();
        test_backpressure();
        test_gapped();
        test_random();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
